// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default word width and the stack
// op encoding, also used by the decode stage.
package stack_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [2:0] stack_op_t;

  localparam stack_op_t OP_NOP   = 3'd0;
  localparam stack_op_t OP_PUSH  = 3'd1;
  localparam stack_op_t OP_DROP  = 3'd2;
  localparam stack_op_t OP_DUP   = 3'd3;
  localparam stack_op_t OP_OVER  = 3'd4;
  localparam stack_op_t OP_SWAP  = 3'd5;
  localparam stack_op_t OP_REPL1 = 3'd6;
  localparam stack_op_t OP_REPL2 = 3'd7;

endpackage

// File: rtl/stack_spill_ram.sv
// Backing store for stack entries below NOS: synchronous write, combinational
// read, no reset (contents are meaningless until written).
module stack_spill_ram #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 62,
  parameter int AW      = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack_unit.sv
// Operand stack with TOS/NOS in registers and deeper entries spilled to an array.
// Optional STACK_HIGHWATER_EN adds a high_water output tracking the peak depth.
module data_stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  stack_op_t        op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top_of_stack,
  output logic [WIDTH-1:0] second_of_stack,
  output logic [CNT_W-1:0] depth,
  output logic             overflow,
`ifdef STACK_HIGHWATER_EN
  output logic             underflow,
  output logic [CNT_W-1:0] high_water
`else
  output logic             underflow
`endif
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic             is_full, has_spill, grow, we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata, push_val, pop_val;
  logic [WIDTH-1:0] tos_n, nos_n;
  logic [CNT_W-1:0] depth_n;
  logic             ovf_n, unf_n;

  assign is_full   = (depth == CNT_W'(DEPTH));
  assign has_spill = (depth > CNT_W'(2));
  assign grow      = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  // Spill pointer is depth-2; the entry just under NOS lives at sp-1.
  assign waddr     = AW'(depth - CNT_W'(2));
  assign raddr     = AW'(depth - CNT_W'(3));
  assign we        = grow && !is_full && (depth >= CNT_W'(2));
  assign pop_val   = has_spill ? rdata : '0;

  always_comb begin
    push_val = din;
    if (op == OP_DUP)  push_val = top_of_stack;
    if (op == OP_OVER) push_val = second_of_stack;
  end

  stack_spill_ram #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .AW(AW)) u_spill (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (second_of_stack),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    tos_n   = top_of_stack;
    nos_n   = second_of_stack;
    depth_n = depth;
    ovf_n   = overflow;
    unf_n   = underflow;
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: begin
        if (is_full) ovf_n = 1'b1;
        else begin
          tos_n   = push_val;
          nos_n   = top_of_stack;
          depth_n = depth + CNT_W'(1);
        end
      end
      OP_DROP: begin
        if (depth == '0) unf_n = 1'b1;
        else begin
          tos_n   = second_of_stack;
          nos_n   = pop_val;
          depth_n = depth - CNT_W'(1);
        end
      end
      OP_SWAP: begin
        tos_n = second_of_stack;
        nos_n = top_of_stack;
      end
      OP_REPL1: begin
        tos_n = din;
        if (depth == '0) depth_n = CNT_W'(1);
      end
      OP_REPL2: begin
        if (depth < CNT_W'(2)) unf_n = 1'b1;
        else begin
          tos_n   = din;
          nos_n   = pop_val;
          depth_n = depth - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      top_of_stack    <= '0;
      second_of_stack <= '0;
      depth           <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      top_of_stack    <= tos_n;
      second_of_stack <= nos_n;
      depth           <= depth_n;
      overflow        <= ovf_n;
      underflow       <= unf_n;
    end
  end

`ifdef STACK_HIGHWATER_EN
  always_ff @(posedge CLK) begin
    if (reset)                  high_water <= '0;
    else if (depth_n > high_water) high_water <= depth_n;
  end
`endif

endmodule

// File: tb/tb_data_stack_unit.sv
// Bench for data_stack_unit: directed scenarios then random ops, all checked
// against a queue-based model of the stack rules.
module tb_data_stack_unit;
  import stack_pkg::*;

  localparam int W = 16;
  localparam int D = 64;
  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  stack_op_t     op = OP_NOP;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  top_of_stack, second_of_stack;
  logic [CW-1:0] depth;
  logic          overflow, underflow;
`ifdef STACK_HIGHWATER_EN
  logic [CW-1:0] high_water;
`endif

  data_stack_unit #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .op              (op),
    .din             (din),
    .top_of_stack    (top_of_stack),
    .second_of_stack (second_of_stack),
    .depth           (depth),
    .overflow        (overflow),
`ifdef STACK_HIGHWATER_EN
    .underflow       (underflow),
    .high_water      (high_water)
`else
    .underflow       (underflow)
`endif
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  // Reference state: the two visible registers plus a queue of buried entries.
  logic [W-1:0] m_tos, m_nos;
  int           m_depth, m_hw;
  logic         m_ovf, m_unf;
  logic [W-1:0] m_buried[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_pop_buried();
    if (m_depth > 2) return m_buried.pop_back();
    return '0;
  endfunction

  task automatic m_push(input logic [W-1:0] v);
    if (m_depth == D) m_ovf = 1'b1;
    else begin
      if (m_depth >= 2) m_buried.push_back(m_nos);
      m_nos = m_tos;
      m_tos = v;
      m_depth++;
    end
  endtask

  task automatic model(input logic r, input stack_op_t o, input logic [W-1:0] v);
    logic [W-1:0] t;
    if (r) begin
      m_tos = '0; m_nos = '0; m_depth = 0; m_ovf = 0; m_unf = 0; m_hw = 0;
      m_buried.delete();
      return;
    end
    case (o)
      OP_PUSH: m_push(v);
      OP_DUP:  m_push(m_tos);
      OP_OVER: m_push(m_nos);
      OP_DROP:
        if (m_depth == 0) m_unf = 1'b1;
        else begin
          m_tos = m_nos;
          m_nos = m_pop_buried();
          m_depth--;
        end
      OP_SWAP: begin t = m_tos; m_tos = m_nos; m_nos = t; end
      OP_REPL1: begin m_tos = v; if (m_depth == 0) m_depth = 1; end
      OP_REPL2:
        if (m_depth < 2) m_unf = 1'b1;
        else begin
          m_tos = v;
          m_nos = m_pop_buried();
          m_depth--;
        end
      default: ;
    endcase
    if (m_depth > m_hw) m_hw = m_depth;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tos"}, 32'(top_of_stack), 32'(m_tos));
    check({tag, ".nos"}, 32'(second_of_stack), 32'(m_nos));
    check({tag, ".depth"}, 32'(depth), 32'(m_depth));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`ifdef STACK_HIGHWATER_EN
    check({tag, ".hw"}, 32'(high_water), 32'(m_hw));
`endif
  endtask

  task automatic step(input logic r, input stack_op_t o, input logic [W-1:0] v);
    @(negedge CLK);
    reset = r; op = o; din = v;
    @(posedge CLK);
    #1;
    model(r, o, v);
    reset = 1'b0; op = OP_NOP;
  endtask

  initial begin
    // Reset state
    step(1'b1, OP_NOP, '0);
    check_all("reset");
    check("reset.tos0", 32'(top_of_stack), 32'd0);

    // PUSH 1,2,3 then REPL2 5
    step(0, OP_PUSH, 1); step(0, OP_PUSH, 2); step(0, OP_PUSH, 3);
    step(0, OP_REPL2, 5);
    check_all("repl2");
    check("repl2.tos", 32'(top_of_stack), 32'd5);
    check("repl2.nos", 32'(second_of_stack), 32'd1);
    check("repl2.depth", 32'(depth), 32'd2);

    // PUSH 1,2, OVER, DUP, DROP x3
    step(1, OP_NOP, 0);
    step(0, OP_PUSH, 1); step(0, OP_PUSH, 2); step(0, OP_OVER, 0); step(0, OP_DUP, 0);
    check("dup.tos", 32'(top_of_stack), 32'd1);
    check("dup.nos", 32'(second_of_stack), 32'd1);
    check("dup.depth", 32'(depth), 32'd4);
    for (int i = 0; i < 3; i++) begin step(0, OP_DROP, 0); check_all("drop3"); end
    check("drop3.tos", 32'(top_of_stack), 32'd1);
    check("drop3.nos", 32'(second_of_stack), 32'd0);
    check("drop3.depth", 32'(depth), 32'd1);

    // PUSH 1,2,3, SWAP, DROP
    step(1, OP_NOP, 0);
    step(0, OP_PUSH, 1); step(0, OP_PUSH, 2); step(0, OP_PUSH, 3);
    step(0, OP_SWAP, 0); step(0, OP_DROP, 0);
    check("swap.tos", 32'(top_of_stack), 32'd3);
    check("swap.nos", 32'(second_of_stack), 32'd1);
    check("swap.depth", 32'(depth), 32'd2);

    // Fill to capacity, overflow, then drain
    step(1, OP_NOP, 0);
    for (int i = 1; i <= D; i++) step(0, OP_PUSH, W'(i));
    step(0, OP_PUSH, 99);
    check_all("full");
    check("full.ovf", 32'(overflow), 32'd1);
    check("full.tos", 32'(top_of_stack), 32'd64);
    check("full.depth", 32'(depth), 32'd64);
    for (int k = 1; k <= D; k++) begin
      step(0, OP_DROP, 0);
      check("drain.tos", 32'(top_of_stack), 32'(D - k));
    end
    check_all("drained");
    check("drained.depth", 32'(depth), 32'd0);

    // Underflow from empty, cleared only by reset
    step(1, OP_NOP, 0);
    step(0, OP_DROP, 0);
    check("unf.flag", 32'(underflow), 32'd1);
    check("unf.tos", 32'(top_of_stack), 32'd0);
    check("unf.depth", 32'(depth), 32'd0);
    step(0, OP_PUSH, 4);
    check("unf.sticky", 32'(underflow), 32'd1);
    step(1, OP_NOP, 0);
    check("unf.cleared", 32'(underflow), 32'd0);

    // Reset beats a simultaneous PUSH
    step(0, OP_PUSH, 3);
    step(1, OP_PUSH, 7);
    check("rstwins.tos", 32'(top_of_stack), 32'd0);
    check("rstwins.depth", 32'(depth), 32'd0);

`ifdef STACK_HIGHWATER_EN
    for (int i = 0; i < 5; i++) step(0, OP_PUSH, W'(i + 10));
    for (int i = 0; i < 3; i++) step(0, OP_DROP, 0);
    check("hw.value", 32'(high_water), 32'd5);
`endif

    // Random ops against the model; growth ops outnumber shrinking ones so
    // both the full and empty boundaries get visited.
    step(1, OP_NOP, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = ($urandom_range(0, 299) == 0);
      step(r, stack_op_t'($urandom_range(0, 7)), W'($urandom));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
